// File: rtl/cag_rgm_pkg.sv
// Shared RGM typedefs used by the register-file front end.
// Response status codes returned on the request/response bus.
package cag_rgm;

  typedef enum logic [1:0] {
    RGM_RSP_OK           = 2'b00,
    RGM_RSP_INVALID_ADDR = 2'b01,
    RGM_RSP_TIMEOUT      = 2'b10
  } rgm_rsp_status_e;

endpackage

// File: rtl/cag_rgm_rf_access_ctrl_if.sv
// Valid/ready request/response bus in front of the RGM.
// master = requester, slave = cag_rgm_rf_access_ctrl.
interface cag_rgm_rf_access_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
);
  import cag_rgm::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  rgm_rsp_status_e   rsp_status;

  modport master (
    output req_valid, req_write, req_addr,
    output req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_status
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_status
  );

endinterface

// File: rtl/cag_rgm_rf_access_ctrl.sv
// Front-end stage of the RGM: one outstanding access,
// strobe generation, response capture and timeout.
module cag_rgm_rf_access_ctrl
  import cag_rgm::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              res,
  cag_rgm_rf_access_ctrl_if.slave bus,
  output logic [ADDR_W-1:0] rf_address,
  output logic              rf_read_en,
  output logic              rf_write_en,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_read_data,
  input  logic              rf_access_complete,
  input  logic              rf_invalid_address
);

  localparam int CNT_W =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  rgm_rsp_status_e   rsp_status_q, rsp_status_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic req_hs;
  logic strobe;
  logic timeout_hit;

  assign bus.req_ready = (state_q == S_IDLE) && !res;
  assign req_hs = bus.req_valid && bus.req_ready;
  assign strobe = rd_en_q || wr_en_q;

  // The strobe cycle does not count toward the timeout.
  assign timeout_hit = TO_EN && !strobe &&
                       (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (req_hs) begin
          state_d = S_ACCESS;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wr_d    = bus.req_write;
          wr_en_d = bus.req_write;
          rd_en_d = !bus.req_write;
        end
      end
      (state_q == S_ACCESS): begin
        if (rf_access_complete) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (wr_q || rf_invalid_address) ?
                        '0 : rf_read_data;
          rsp_status_d = rf_invalid_address ?
                         RGM_RSP_INVALID_ADDR : RGM_RSP_OK;
        end else if (timeout_hit) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = '0;
          rsp_status_d = RGM_RSP_TIMEOUT;
        end
      end
      (state_q == S_RESP): begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= RGM_RSP_OK;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (state_q == S_ACCESS && !strobe &&
                 cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign rf_address     = addr_q;
  assign rf_write_data  = wdata_q;
  assign rf_read_en     = rd_en_q;
  assign rf_write_en    = wr_en_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_status = rsp_status_q;

endmodule

// File: tb/tb_cag_rgm_rf_access_ctrl.sv
// Directed bench for cag_rgm_rf_access_ctrl:
// vector table plus timeout/backpressure/reset sequences.
module tb_cag_rgm_rf_access_ctrl;

  localparam int AW = 10;
  localparam int DW = 64;

  logic          clk;
  logic          res;
  logic [AW-1:0] rf_address;
  logic          rf_read_en;
  logic          rf_write_en;
  logic [DW-1:0] rf_write_data;
  logic [DW-1:0] rf_read_data;
  logic          rf_access_complete;
  logic          rf_invalid_address;

  int n_tests = 0;
  int n_fail  = 0;

  cag_rgm_rf_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  cag_rgm_rf_access_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(8)
  ) dut (
    .clk               (clk),
    .res               (res),
    .bus               (bus.slave),
    .rf_address        (rf_address),
    .rf_read_en        (rf_read_en),
    .rf_write_en       (rf_write_en),
    .rf_write_data     (rf_write_data),
    .rf_read_data      (rf_read_data),
    .rf_access_complete(rf_access_complete),
    .rf_invalid_address(rf_invalid_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic [9:0]  addr;
    logic [63:0] wdata;
    int          dly;
    logic        inv;
    logic [63:0] rf_rd;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_status;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] st();
    return {62'b0, bus.rsp_status};
  endfunction

  // Starts and ends at a negedge with the DUT idle.
  task automatic run_vec(input vec_t v);
    bus.req_write = v.wr;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_valid = 1'b1;
    #1 chk({v.name, ".req_ready"}, 64'(bus.req_ready), 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk({v.name, ".rd_en"}, 64'(rf_read_en), 64'(!v.wr));
    chk({v.name, ".wr_en"}, 64'(rf_write_en), 64'(v.wr));
    chk({v.name, ".addr"}, 64'(rf_address), 64'(v.addr));
    chk({v.name, ".wdata"}, rf_write_data, v.wdata);
    rf_read_data       = v.rf_rd;
    rf_invalid_address = v.inv;
    rf_access_complete = (v.dly == 0);
    for (int k = 1; k <= v.dly; k++) begin
      @(negedge clk);
      chk({v.name, ".strobe_low"},
          64'(rf_read_en | rf_write_en), 0);
      chk({v.name, ".addr_hold"}, 64'(rf_address),
          64'(v.addr));
      chk({v.name, ".rsp_early"}, 64'(bus.rsp_valid), 0);
      rf_access_complete = (k == v.dly);
    end
    @(negedge clk);
    rf_access_complete = 1'b0;
    rf_invalid_address = 1'b0;
    chk({v.name, ".strobe_off"},
        64'(rf_read_en | rf_write_en), 0);
    chk({v.name, ".rsp_valid"}, 64'(bus.rsp_valid), 1);
    chk({v.name, ".rdata"}, bus.rsp_rdata, v.exp_rdata);
    chk({v.name, ".status"}, st(), 64'(v.exp_status));
    chk({v.name, ".busy"}, 64'(bus.req_ready), 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({v.name, ".rsp_drop"}, 64'(bus.rsp_valid), 0);
    chk({v.name, ".idle"}, 64'(bus.req_ready), 1);
  endtask

  initial begin
    vecs[0] = '{"read", 1'b0, 10'h012, 64'h0, 1, 1'b0,
                64'hDEAD_BEEF_0000_0001,
                64'hDEAD_BEEF_0000_0001, 2'b00};
    vecs[1] = '{"write", 1'b1, 10'h3FF,
                64'hA5A5_A5A5_A5A5_A5A5, 0, 1'b0,
                64'h1234, 64'h0, 2'b00};
    vecs[2] = '{"inv_rd", 1'b0, 10'h200, 64'h0, 0, 1'b1,
                64'hFFFF, 64'h0, 2'b01};
    vecs[3] = '{"slow_rd", 1'b0, 10'h001, 64'h0, 3, 1'b0,
                64'h0123_4567_89AB_CDEF,
                64'h0123_4567_89AB_CDEF, 2'b00};
    vecs[4] = '{"inv_wr", 1'b1, 10'h000,
                64'h5555_0000_5555_0000, 2, 1'b1,
                64'h77, 64'h0, 2'b01};

    res                = 1'b1;
    bus.req_valid      = 1'b0;
    bus.req_write      = 1'b0;
    bus.req_addr       = '0;
    bus.req_wdata      = '0;
    bus.rsp_ready      = 1'b0;
    rf_read_data       = '0;
    rf_access_complete = 1'b0;
    rf_invalid_address = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst.rsp_valid", 64'(bus.rsp_valid), 0);
    chk("rst.strobes", 64'(rf_read_en | rf_write_en), 0);
    chk("rst.status", st(), 0);
    chk("rst.rdata", bus.rsp_rdata, 0);
    chk("rst.addr", 64'(rf_address), 0);
    chk("rst.wdata", rf_write_data, 0);
    chk("rst.req_ready", 64'(bus.req_ready), 0);
    res = 1'b0;
    #1 chk("rst.rel_ready", 64'(bus.req_ready), 1);
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Timeout: no completion for TIMEOUT=8 cycles
    bus.req_write = 1'b0;
    bus.req_addr  = 10'h055;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("to.rd_en", 64'(rf_read_en), 1);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n < 9) chk("to.wait", 64'(bus.rsp_valid), 0);
    end
    chk("to.rsp_valid", 64'(bus.rsp_valid), 1);
    chk("to.status", st(), 2);
    chk("to.rdata", bus.rsp_rdata, 0);
    rf_access_complete = 1'b1;
    rf_invalid_address = 1'b1;
    rf_read_data       = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (2) begin
      @(negedge clk);
      chk("to.late_status", st(), 2);
      chk("to.late_rdata", bus.rsp_rdata, 0);
      chk("to.late_valid", 64'(bus.rsp_valid), 1);
    end
    rf_access_complete = 1'b0;
    rf_invalid_address = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("to.drop", 64'(bus.rsp_valid), 0);
    rf_access_complete = 1'b1;
    @(negedge clk);
    rf_access_complete = 1'b0;
    chk("idle_cmpl.valid", 64'(bus.rsp_valid), 0);
    chk("idle_cmpl.ready", 64'(bus.req_ready), 1);

    // Backpressure with a second request waiting
    bus.req_write = 1'b0;
    bus.req_addr  = 10'h0AA;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_addr       = 10'h0BB;
    rf_read_data       = 64'h1111;
    rf_access_complete = 1'b1;
    @(negedge clk);
    rf_access_complete = 1'b0;
    rf_read_data       = 64'h9999;
    for (int c = 0; c < 20; c++) begin
      chk("bp.valid", 64'(bus.rsp_valid), 1);
      chk("bp.rdata", bus.rsp_rdata, 64'h1111);
      chk("bp.status", st(), 0);
      chk("bp.req_ready", 64'(bus.req_ready), 0);
      chk("bp.no_strobe", 64'(rf_read_en), 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1 chk("bp.hs_ready", 64'(bus.req_ready), 0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("bp.drop", 64'(bus.rsp_valid), 0);
    chk("bp.ready", 64'(bus.req_ready), 1);
    chk("bp.not_yet", 64'(rf_read_en), 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("bp2.rd_en", 64'(rf_read_en), 1);
    chk("bp2.addr", 64'(rf_address), 64'h0BB);
    rf_read_data       = 64'h2222;
    rf_access_complete = 1'b1;
    @(negedge clk);
    rf_access_complete = 1'b0;
    chk("bp2.rdata", bus.rsp_rdata, 64'h2222);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("bp2.drop", 64'(bus.rsp_valid), 0);

    // Reset two cycles after the strobe
    bus.req_write = 1'b1;
    bus.req_addr  = 10'h155;
    bus.req_wdata = 64'hCAFE_F00D_1234_5678;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mr.wr_en", 64'(rf_write_en), 1);
    repeat (2) @(negedge clk);
    res                = 1'b1;
    rf_access_complete = 1'b1;
    #1 chk("mr.ready_low", 64'(bus.req_ready), 0);
    @(negedge clk);
    chk("mr.rsp_valid", 64'(bus.rsp_valid), 0);
    chk("mr.strobes", 64'(rf_read_en | rf_write_en), 0);
    chk("mr.addr", 64'(rf_address), 0);
    chk("mr.wdata", rf_write_data, 0);
    chk("mr.status", st(), 0);
    chk("mr.rdata", bus.rsp_rdata, 0);
    res = 1'b0;
    #1 chk("mr.ready", 64'(bus.req_ready), 1);
    @(negedge clk);
    rf_access_complete = 1'b0;
    chk("mr.late", 64'(bus.rsp_valid), 0);
    chk("mr.ready2", 64'(bus.req_ready), 1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
